// File: rtl/wm8731_i2c_cfg_ctrl.sv
// WM8731 configuration sequencer: walks the register LUT and writes each
// 16-bit word to the codec as a 3-byte I2C write, with per-word NACK retry.
module wm8731_i2c_cfg_ctrl #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned I2C_FREQ  = 100_000,
    parameter int unsigned LUT_SIZE  = 10,
    parameter logic [7:0]  DEV_ADDR  = 8'h34,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iSTART,
    output logic [7:0]  LUT_INDEX,
    input  logic [15:0] LUT_DATA,
    output logic        I2C_SCLK,
    output logic        I2C_SDAT_OE,
    input  logic        I2C_SDAT_IN,
    output logic        CFG_BUSY,
    output logic        CFG_DONE,
    output logic        CFG_ERR
);

    localparam int unsigned Q  = CLK_FREQ / (4 * I2C_FREQ);
    localparam int unsigned QW = (Q > 1) ? $clog2(Q) : 1;
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [QW-1:0] Q_LAST    = QW'(Q - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [7:0]    LUT_LAST  = 8'(LUT_SIZE - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_START,
        ST_BYTE,
        ST_ACK,
        ST_STOP,
        ST_NEXT,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t        state, state_n;
    logic [QW-1:0] qcnt, qcnt_n;
    logic [1:0]    phase, phase_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [1:0]    byte_cnt, byte_cnt_n;
    logic [23:0]   shreg, shreg_n;
    logic [7:0]    index_n;
    logic [RW-1:0] retry, retry_n;
    logic          nack, nack_n;
    logic          scl_n, oe_n;
    logic          busy_n, done_n, err_n;
    logic [1:0]    sda_sync;
    logic          sda_s;
    logic          tick_end, last_tick, timed;

    assign sda_s     = sda_sync[1];
    assign timed     = (state == ST_START) || (state == ST_BYTE) ||
                       (state == ST_ACK)   || (state == ST_STOP);
    assign tick_end  = (qcnt == Q_LAST);
    assign last_tick = tick_end && (phase == 2'd3);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state       <= ST_IDLE;
            qcnt        <= '0;
            phase       <= '0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            shreg       <= '0;
            LUT_INDEX   <= '0;
            retry       <= '0;
            nack        <= 1'b0;
            I2C_SCLK    <= 1'b1;
            I2C_SDAT_OE <= 1'b0;
            CFG_BUSY    <= 1'b0;
            CFG_DONE    <= 1'b0;
            CFG_ERR     <= 1'b0;
            sda_sync    <= '1;
        end else begin
            state       <= state_n;
            qcnt        <= qcnt_n;
            phase       <= phase_n;
            bit_cnt     <= bit_cnt_n;
            byte_cnt    <= byte_cnt_n;
            shreg       <= shreg_n;
            LUT_INDEX   <= index_n;
            retry       <= retry_n;
            nack        <= nack_n;
            I2C_SCLK    <= scl_n;
            I2C_SDAT_OE <= oe_n;
            CFG_BUSY    <= busy_n;
            CFG_DONE    <= done_n;
            CFG_ERR     <= err_n;
            sda_sync    <= {sda_sync[0], I2C_SDAT_IN};
        end
    end

    always_comb begin
        state_n    = state;
        qcnt_n     = qcnt;
        phase_n    = phase;
        bit_cnt_n  = bit_cnt;
        byte_cnt_n = byte_cnt;
        shreg_n    = shreg;
        index_n    = LUT_INDEX;
        retry_n    = retry;
        nack_n     = nack;

        if (timed) begin
            if (tick_end) begin
                qcnt_n  = '0;
                phase_n = phase + 2'd1;
            end else begin
                qcnt_n = qcnt + 1'b1;
            end
        end

        case (state)
            ST_IDLE: begin
                index_n = '0;
                retry_n = '0;
                state_n = ST_FETCH;
            end
            // phase doubles as the 2-cycle counter while waiting on the registered LUT
            ST_FETCH: begin
                if (phase == 2'd0) begin
                    phase_n = 2'd1;
                end else begin
                    phase_n    = '0;
                    qcnt_n     = '0;
                    shreg_n    = {DEV_ADDR, LUT_DATA};
                    byte_cnt_n = '0;
                    bit_cnt_n  = '0;
                    nack_n     = 1'b0;
                    state_n    = ST_START;
                end
            end
            ST_START: begin
                if (last_tick) state_n = ST_BYTE;
            end
            ST_BYTE: begin
                if (last_tick) begin
                    shreg_n   = {shreg[22:0], 1'b0};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = ST_ACK;
                end
            end
            ST_ACK: begin
                if (tick_end && (phase == 2'd2)) nack_n = sda_s;
                if (last_tick) begin
                    if (nack) begin
                        state_n = ST_STOP;
                    end else if (byte_cnt < 2'd2) begin
                        byte_cnt_n = byte_cnt + 2'd1;
                        state_n    = ST_BYTE;
                    end else begin
                        state_n = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (last_tick) begin
                    if (nack) begin
                        if (retry < RETRY_MAX) begin
                            retry_n = retry + 1'b1;
                            state_n = ST_FETCH;
                        end else begin
                            state_n = ST_ERR;
                        end
                    end else begin
                        state_n = ST_NEXT;
                    end
                end
            end
            ST_NEXT: begin
                retry_n = '0;
                index_n = LUT_INDEX + 8'd1;
                state_n = (LUT_INDEX == LUT_LAST) ? ST_DONE : ST_FETCH;
            end
            ST_DONE, ST_ERR: begin
                if (iSTART) begin
                    index_n = '0;
                    retry_n = '0;
                    state_n = ST_FETCH;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Bus levels are registered from the next state/phase so they line up with the tick.
        scl_n = 1'b1;
        oe_n  = 1'b0;
        case (state_n)
            ST_START: begin
                scl_n = (phase_n != 2'd3);
                oe_n  = (phase_n >= 2'd2);
            end
            ST_BYTE: begin
                scl_n = (phase_n == 2'd1) || (phase_n == 2'd2);
                oe_n  = ~shreg_n[23];
            end
            ST_ACK: begin
                scl_n = (phase_n == 2'd1) || (phase_n == 2'd2);
                oe_n  = 1'b0;
            end
            ST_STOP: begin
                scl_n = (phase_n != 2'd0);
                oe_n  = (phase_n != 2'd3);
            end
            default: begin
                scl_n = 1'b1;
                oe_n  = 1'b0;
            end
        endcase

        busy_n = (state_n == ST_FETCH) || (state_n == ST_START) || (state_n == ST_BYTE) ||
                 (state_n == ST_ACK)   || (state_n == ST_STOP)  || (state_n == ST_NEXT);
        done_n = (state_n == ST_DONE);
        err_n  = (state_n == ST_ERR);
    end

endmodule

// File: tb/tb_wm8731_i2c_cfg_ctrl.sv
// Bench for wm8731_i2c_cfg_ctrl: LUT model, I2C slave/bus monitor, vector table of frames.
module tb_wm8731_i2c_cfg_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  lut_index;
    logic [15:0] lut_data = 16'h0000;
    logic        scl, oe, sda_in, busy, done, err;
    logic        slave_low = 1'b0;

    assign sda_in = ~(oe | slave_low);

    always #5 clk = ~clk;

    wm8731_i2c_cfg_ctrl #(
        .CLK_FREQ (4_000_000),
        .I2C_FREQ (100_000),
        .LUT_SIZE (10),
        .DEV_ADDR (8'h34),
        .MAX_RETRY(3)
    ) dut (
        .iCLK       (clk),
        .iRST_N     (rst_n),
        .iSTART     (start),
        .LUT_INDEX  (lut_index),
        .LUT_DATA   (lut_data),
        .I2C_SCLK   (scl),
        .I2C_SDAT_OE(oe),
        .I2C_SDAT_IN(sda_in),
        .CFG_BUSY   (busy),
        .CFG_DONE   (done),
        .CFG_ERR    (err)
    );

    typedef struct {
        logic [15:0] lut_word;
        logic [7:0]  exp_addr;
        logic [7:0]  exp_hi;
        logic [7:0]  exp_lo;
    } vec_t;

    vec_t vecs [10];

    int checks = 0;
    int errors = 0;

    always @(posedge clk) begin
        if (lut_index < 8'd10) lut_data <= vecs[int'(lut_index)].lut_word;
        else                   lut_data <= 16'h0000;
    end

    // Slave + monitor state
    int         slave_mode = 0;
    logic       scl_q = 1'b1, sda_q = 1'b1;
    int         bitpos = 0, byte_idx = 0;
    logic [7:0] shreg_m = 8'h00;
    logic [7:0] cb [3];
    int         fr_n = 0;
    int         fr_len [64];
    logic [7:0] fr_b0 [64], fr_b1 [64], fr_b2 [64];
    int         starts = 0, stops = 0, per_err = 0, stab_err = 0;
    int         cyc = 0, last_rise = 0, nack_cnt = 0;
    bit         have_rise = 1'b0, in_bit = 1'b0;
    logic       sda_at_rise = 1'b1;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        scl_q <= scl;
        sda_q <= sda_in;
        if (slave_mode != 1) nack_cnt <= 0;
        if (!rst_n) begin
            bitpos    <= 0;
            byte_idx  <= 0;
            slave_low <= 1'b0;
            have_rise <= 1'b0;
            in_bit    <= 1'b0;
        end else if (scl_q && scl && sda_q && !sda_in) begin
            starts    <= starts + 1;
            bitpos    <= 0;
            byte_idx  <= 0;
            slave_low <= 1'b0;
            have_rise <= 1'b0;
            in_bit    <= 1'b0;
            cb[0] <= 8'h00; cb[1] <= 8'h00; cb[2] <= 8'h00;
        end else if (scl_q && scl && !sda_q && sda_in) begin
            stops  <= stops + 1;
            in_bit <= 1'b0;
            if (fr_n < 64) begin
                fr_len[fr_n] <= byte_idx;
                fr_b0[fr_n]  <= cb[0];
                fr_b1[fr_n]  <= cb[1];
                fr_b2[fr_n]  <= cb[2];
            end
            fr_n <= fr_n + 1;
        end else if (!scl_q && scl) begin
            if (have_rise && (cyc - last_rise != 40)) per_err <= per_err + 1;
            have_rise   <= 1'b1;
            last_rise   <= cyc;
            in_bit      <= 1'b1;
            sda_at_rise <= sda_in;
            if (bitpos < 8) begin
                shreg_m <= {shreg_m[6:0], sda_in};
                bitpos  <= bitpos + 1;
            end else if (bitpos == 8) begin
                bitpos <= 9;
            end
        end else if (scl_q && !scl) begin
            if (in_bit && (sda_in != sda_at_rise)) stab_err <= stab_err + 1;
            in_bit <= 1'b0;
            if (bitpos == 8) begin
                if (byte_idx < 3) cb[byte_idx] <= shreg_m;
                slave_low <= 1'b1;
                if (slave_mode == 2 && byte_idx == 0) slave_low <= 1'b0;
                if (slave_mode == 1 && byte_idx == 2 && cb[1] == 8'h08 && nack_cnt < 2) begin
                    slave_low <= 1'b0;
                    nack_cnt  <= nack_cnt + 1;
                end
            end else if (bitpos == 9) begin
                slave_low <= 1'b0;
                bitpos    <= 0;
                byte_idx  <= byte_idx + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_frame(input string tag, input int slot, input int vi);
        chk($sformatf("%s_len[%0d]", tag, slot), fr_len[slot], 3);
        chk($sformatf("%s_addr[%0d]", tag, slot), {24'h0, fr_b0[slot]}, {24'h0, vecs[vi].exp_addr});
        chk($sformatf("%s_hi[%0d]", tag, slot), {24'h0, fr_b1[slot]}, {24'h0, vecs[vi].exp_hi});
        chk($sformatf("%s_lo[%0d]", tag, slot), {24'h0, fr_b2[slot]}, {24'h0, vecs[vi].exp_lo});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts negedges until CFG_DONE or CFG_ERR, optionally pulsing iSTART mid-run.
    task automatic wait_end(input int bound, input int pulse_at, output int cnt);
        cnt = 0;
        while (!(done || err) && cnt < bound) begin
            start = (cnt == pulse_at) ? 1'b1 : 1'b0;
            @(negedge clk);
            cnt++;
        end
        start = 1'b0;
    endtask

    int cnt, base, s0, p0, w;
    int retry_order [12];

    initial begin
        vecs[0] = '{16'h0017, 8'h34, 8'h00, 8'h17};
        vecs[1] = '{16'h0217, 8'h34, 8'h02, 8'h17};
        vecs[2] = '{16'h0471, 8'h34, 8'h04, 8'h71};
        vecs[3] = '{16'h0671, 8'h34, 8'h06, 8'h71};
        vecs[4] = '{16'h087A, 8'h34, 8'h08, 8'h7A};
        vecs[5] = '{16'h0A08, 8'h34, 8'h0A, 8'h08};
        vecs[6] = '{16'h0C00, 8'h34, 8'h0C, 8'h00};
        vecs[7] = '{16'h0E02, 8'h34, 8'h0E, 8'h02};
        vecs[8] = '{16'h1018, 8'h34, 8'h10, 8'h18};
        vecs[9] = '{16'h1201, 8'h34, 8'h12, 8'h01};
        retry_order = '{0, 1, 2, 3, 4, 4, 4, 5, 6, 7, 8, 9};

        repeat (5) @(negedge clk);
        chk("rst_lut_index", {24'h0, lut_index}, 0);
        chk("rst_scl", {31'h0, scl}, 1);
        chk("rst_oe", {31'h0, oe}, 0);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_done", {31'h0, done}, 0);
        chk("rst_err", {31'h0, err}, 0);

        // Run 1: all ACKed, exact sequence length
        rst_n = 1'b1;
        base = fr_n; s0 = starts; p0 = stops;
        @(negedge clk);
        chk("run1_busy_after_idle", {31'h0, busy}, 1);
        wait_end(20000, -1, cnt);
        chk("run1_cycles", cnt, 11630);
        chk("run1_done", {31'h0, done}, 1);
        chk("run1_err", {31'h0, err}, 0);
        chk("run1_busy", {31'h0, busy}, 0);
        chk("run1_frames", fr_n - base, 10);
        chk("run1_starts", starts - s0, 10);
        chk("run1_stops", stops - p0, 10);
        for (int i = 0; i < 10; i++) chk_frame("run1", base + i, i);
        chk("run1_scl_period_errs", per_err, 0);
        chk("run1_sda_stable_errs", stab_err, 0);

        // Run 2: restart from DONE, with an ignored iSTART mid-run
        base = fr_n;
        pulse_start();
        chk("run2_busy", {31'h0, busy}, 1);
        chk("run2_done_cleared", {31'h0, done}, 0);
        wait_end(20000, 3000, cnt);
        chk("run2_cycles", cnt, 11630);
        chk("run2_done", {31'h0, done}, 1);
        chk("run2_frames", fr_n - base, 10);
        for (int i = 0; i < 10; i++) chk_frame("run2", base + i, i);

        // Run 3: data-low byte of word 4 NACKed twice
        slave_mode = 1;
        base = fr_n;
        pulse_start();
        wait_end(30000, -1, cnt);
        chk("run3_cycles", cnt, 11630 + 2 * 1162);
        chk("run3_done", {31'h0, done}, 1);
        chk("run3_err", {31'h0, err}, 0);
        chk("run3_frames", fr_n - base, 12);
        for (int i = 0; i < 12; i++) begin
            w = retry_order[i];
            chk_frame("run3", base + i, w);
        end

        // Run 4: address always NACKed -> retries exhausted
        slave_mode = 2;
        base = fr_n;
        pulse_start();
        wait_end(10000, -1, cnt);
        chk("run4_cycles", cnt, 4 * 442);
        chk("run4_err", {31'h0, err}, 1);
        chk("run4_done", {31'h0, done}, 0);
        chk("run4_busy", {31'h0, busy}, 0);
        chk("run4_lut_index", {24'h0, lut_index}, 0);
        chk("run4_scl_idle", {31'h0, scl}, 1);
        chk("run4_oe_idle", {31'h0, oe}, 0);
        chk("run4_frames", fr_n - base, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("run4_len[%0d]", i), fr_len[base + i], 1);
            chk($sformatf("run4_addr[%0d]", i), {24'h0, fr_b0[base + i]}, 32'h34);
        end

        // Run 5: reset mid-bit of word 6
        slave_mode = 0;
        pulse_start();
        chk("run5_busy", {31'h0, busy}, 1);
        cnt = 0;
        while (lut_index != 8'd6 && cnt < 20000) begin
            @(negedge clk);
            cnt++;
        end
        chk("run5_reached_word6", {24'h0, lut_index}, 6);
        repeat (75) @(negedge clk);
        chk("run5_pre_scl_low", {31'h0, scl}, 0);
        chk("run5_pre_oe_drive", {31'h0, oe}, 1);
        rst_n = 1'b0;
        #1;
        chk("run5_rst_scl", {31'h0, scl}, 1);
        chk("run5_rst_oe", {31'h0, oe}, 0);
        chk("run5_rst_busy", {31'h0, busy}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base = fr_n;
        cnt = 0;
        while (fr_n == base && cnt < 3000) begin
            @(negedge clk);
            cnt++;
        end
        chk("run5_frame_seen", {31'h0, (fr_n > base)}, 1);
        chk_frame("run5", base, 0);
        chk("run5_done", {31'h0, done}, 0);

        chk("final_scl_period_errs", per_err, 0);
        chk("final_sda_stable_errs", stab_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wm8731_i2c_cfg_ctrl.md
# wm8731_i2c_cfg_ctrl

Sequencer that walks the WM8731 configuration look-up table and writes each entry to the codec over a two-wire (I2C) bus. It drives the LUT index and latches the registered 16-bit LUT word. It serialises each word as a 3-byte write: device address, then data high byte, then data low byte. It checks every ACK, retries on NACK, and flags completion or failure to the audio top level. It sits between the config LUT and the codec control pins and runs once after reset, or again on request.

## Interface
- CLK_FREQ, 50_000_000: iCLK frequency in Hz.
- I2C_FREQ, 100_000: SCL frequency in Hz; CLK_FREQ/(4*I2C_FREQ) must be an integer of at least 2.
- LUT_SIZE, 10: number of LUT entries written, at indices 0..LUT_SIZE-1.
- DEV_ADDR, 8'h34: write address byte (7-bit address 0x1A, R/W=0).
- MAX_RETRY, 3: maximum re-sends of one word after a NACK.

Ports:
- iCLK  in  1  system clock.
- iRST_N  in  1  reset: asynchronous, active-low (iRST_N, clock iCLK).
- iSTART  in  1  single-cycle pulse; restarts the sequence from index 0. Honoured only in DONE or ERR.
- LUT_INDEX  out  8  LUT address.
- LUT_DATA  in  16  LUT word, registered in the LUT (valid 1 cycle after LUT_INDEX changes).
- I2C_SCLK  out  1  SCL, push-pull.
- I2C_SDAT_OE  out  1  1 = pull SDA low; 0 = release.
- I2C_SDAT_IN  in  1  SDA pin level.
- CFG_BUSY  out  1  sequence in progress.
- CFG_DONE  out  1  all words acknowledged; held until next start.
- CFG_ERR  out  1  retries exhausted; held until next start.

## Operation
- Quarter-bit tick: counter of Q = CLK_FREQ/(4*I2C_FREQ) cycles. It runs only while in START, BYTE, ACK or STOP. It resets to 0 on entry to START.
- States: IDLE, FETCH, START, BYTE, ACK, STOP, NEXT, DONE, ERR.
- IDLE: entered from reset. Moves to FETCH on the first cycle after reset release, with index=0 and retry=0.
- FETCH (2 cycles): LUT_INDEX = index. On the 2nd cycle, latch {DEV_ADDR, LUT_DATA[15:8], LUT_DATA[7:0]} into a 24-bit shift register and set byte_cnt=0.
- START (4 ticks):
  - ticks 0-1: SDA released, SCL=1.
  - tick 2: SDA low.
  - tick 3: SCL=0.
- BYTE (8 bits, MSB first, 4 ticks per bit):
  - tick 0: SCL=0 and SDA driven from the shift register MSB (OE = ~bit).
  - ticks 1-2: SCL=1.
  - tick 3: SCL=0.
  - Shift after tick 3.
- ACK (4 ticks): SDA released.
  - Sample I2C_SDAT_IN at tick 2.
  - Sample 0 (ACK): go to BYTE if byte_cnt<2 (byte_cnt++), else go to STOP.
  - Sample 1 (NACK): go to STOP with the nack flag set.
- STOP (4 ticks):
  - tick 0: SCL=0, SDA low.
  - tick 1: SCL=1.
  - tick 3: SDA released.
  - Then:
    - If nack and retry<MAX_RETRY: retry++, go to FETCH (same index).
    - If nack and retry=MAX_RETRY: go to ERR.
    - Otherwise: go to NEXT.
- NEXT (1 cycle): retry=0, index++. Go to DONE if index=LUT_SIZE, else go to FETCH.
- DONE / ERR: bus idle (SCL=1, SDA released), flag held. iSTART clears the flags, sets index=0 and retry=0, and goes to FETCH.
- iSTART in any other state is ignored.
- Index width is 8 bits. LUT_SIZE ≤ 255, so there is no wrap.

## Timing
- Reset values (asynchronous):
  - Outputs: LUT_INDEX=0, I2C_SCLK=1, I2C_SDAT_OE=0, CFG_BUSY=0, CFG_DONE=0, CFG_ERR=0.
  - Internal: state=IDLE, all counters 0.
- Reset mid-transfer: bus released immediately (SCL=1, SDA released). No STOP is generated. The sequence restarts from index 0 after release.
- CFG_BUSY=1 in FETCH through NEXT; 0 in IDLE, DONE and ERR.
- All outputs are registered; each changes at most once per tick boundary.
- Word time, not counting FETCH/NEXT: START 4Q + 3×(8+1)×4Q + STOP 4Q = 116Q cycles.
- Full sequence with no NACK: LUT_SIZE×(116Q+3) cycles. CFG_DONE rises on the cycle after the final NEXT.
- SDA changes only while SCL=0, except at START and STOP.

## Test plan
- Params CLK_FREQ=4_000_000, I2C_FREQ=100_000 (Q=10). Use an LUT model with entries 0x0017, 0x0217, 0x0471, 0x0671, 0x087A, 0x0A08, 0x0C00, 0x0E02, 0x1018, 0x1201. A slave model ACKs everything. Required: the bus decodes 10 frames 34-00-17 … 34-12-01, and CFG_DONE=1 exactly 10×1163 cycles after reset release.
- Timing check: SCL period = 40 cycles. SDA is stable while SCL is high in every data bit. A START and a STOP condition occur per word.
- Slave NACKs the data-low byte of word 4 twice, then ACKs. Required: frame 34-08-7A appears 3 times, then word 5 follows, and CFG_DONE=1 with CFG_ERR=0.
- Slave always NACKs the address byte. Required: 4 attempts at word 0, then CFG_ERR=1, CFG_BUSY=0, LUT_INDEX=0, bus idle.
- iRST_N asserted mid-bit of word 6. Required: SCL=1 and SDA_OE=0 in the same cycle. After release, the first frame is 34-00-17.
- Pulse iSTART in DONE: the full sequence reruns. Pulse iSTART while BUSY: no effect on the frame sequence.
